word_split_tx: RTL and testbench
================================

WORD_SPLIT_TX -- requirements
Module: word_split_tx

Interface
- REQ-001: Parameter DEPTH, default 4, sets buffer depth in 20-bit words; power of two, minimum 2.
- REQ-002: Parameter FRAME_LEN, default 8, sets data words per frame; range 1..255.
- REQ-003: clk  input  1  single clock; all state changes on its rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: in_data  input  20  result word to transmit.
- REQ-006: in_valid  input  1  in_data valid.
- REQ-007: in_ready  output  1  block can accept a word this cycle.
- REQ-008: out_data  output  10  transmitted half-word.
- REQ-009: out_valid  output  1  out_data valid.
- REQ-010: out_ready  input  1  sink accepts out_data this cycle.
- REQ-011: out_last  output  1  out_data is the final half-word of a frame.
- REQ-012: count  output  $clog2(DEPTH)+1  current buffer occupancy in words.

Function
- REQ-013: Push occurs when in_valid and in_ready are both 1; pop occurs on the out handshake of a word's high half.
- REQ-014: in_ready is 1 when count < DEPTH; it does not depend on out_ready, so there is no bypass path when full.
- REQ-015: Simultaneous push and pop leaves count unchanged; push alone adds 1; pop alone subtracts 1.
- REQ-016: Buffer pointers wrap modulo DEPTH.
- REQ-017: Output FSM states are IDLE, LOW and HIGH, plus CS_LO and CS_HI when CHECKSUM_EN is defined.
- REQ-018: IDLE goes to LOW when count > 0.
- REQ-019: LOW presents head word bits [9:0] and goes to HIGH on the out handshake.
- REQ-020: HIGH presents head word bits [19:10] and, on the out handshake, pops the word and increments the frame counter.
- REQ-021: After a HIGH handshake the FSM goes to LOW if count > 0 after the pop, otherwise to IDLE; the checksum exception is REQ-030.
- REQ-022: out_data, out_valid and out_last are registered; out_valid is 1 in every state except IDLE.
- REQ-023: Latency: a word pushed into an empty block at edge N gives out_valid = 1 with its low half after edge N+1.
- REQ-024: While out_valid = 1 and out_ready = 0, out_data and out_last hold stable.
- REQ-025: Without checksum, out_last = 1 on the HIGH half of word number FRAME_LEN, and the frame counter then wraps to 0.
- REQ-026: out_ready is ignored while out_valid = 0.

Reset
- REQ-027: When rst_n = 0, the following are forced asynchronously:
  - FSM to IDLE; pointers, count, frame counter and checksum to 0;
  - out_data = 0, out_valid = 0, out_last = 0;
  - in_ready = 1 is visible while reset is held.
- REQ-028: Reset mid-frame discards all buffered words and the partial frame; no half-word is emitted until a new push after rst_n returns to 1.

Configuration
- REQ-029: Macro WORD_SPLIT_TX_CHECKSUM_EN, when defined, keeps a 20-bit running XOR of every word popped in the current frame.
- REQ-030: With the macro defined, the HIGH handshake of word FRAME_LEN goes to CS_LO instead of LOW or IDLE.
- REQ-031: CS_LO sends checksum [9:0]; CS_HI then sends checksum [19:10] with out_last = 1.
- REQ-032: On the CS_HI handshake, the checksum and frame counter clear and the FSM returns to LOW or IDLE per count.
- REQ-033: The checksum includes the word popped on the final HIGH handshake; the buffer keeps accepting pushes during CS_LO and CS_HI.
- REQ-034: Without the macro, CS_LO, CS_HI and the checksum register do not exist, and behaviour is exactly REQ-025.

Verification
- REQ-035: Push 0xABCDE with out_ready = 1:
  - out_data 0x0DE, then 0x2AF, on consecutive cycles;
  - count returns to 0;
  - out_last = 0 (FRAME_LEN = 8).
- REQ-036: out_ready = 0, push 4 words (DEPTH = 4):
  - count = 4 and in_ready = 0;
  - a 5th in_valid is not accepted;
  - out_data holds 0x low half of word 1 throughout.
- REQ-037: Without macro, stream words 0x00001..0x00008:
  - 16 half-words out;
  - out_last = 1 only on the 16th, value 0x000.
- REQ-038: With macro, same stream as REQ-037:
  - 18 half-words out;
  - 17th = 0x008 and 18th = 0x000 with out_last = 1 (XOR of 1..8 = 8).
- REQ-039: With out_ready toggling every cycle and a continuous push at full rate, no word is lost or duplicated and order is preserved over 64 words.
- REQ-040: Assert rst_n = 0 during the HIGH state of word 3 with 2 words buffered:
  - immediately out_valid = 0, count = 0, in_ready = 1;
  - a next push of 0x12345 emits 0x345 then 0x048;
  - the frame counter restarts.

Source files
------------

// File: rtl/word_split_tx_if.sv
// Purpose : handshake bundle for word_split_tx (20-bit word in, 10-bit half-word out).
// Latency : n/a (wiring only).
// Backpr. : in side valid/ready, out side valid/ready; ready may be low indefinitely.
// Ports   : in_data/in_valid/in_ready (upstream word), out_data/out_valid/out_ready/out_last (half-word stream).
//           master = the surrounding environment driving words and sinking half-words; slave = word_split_tx.
interface word_split_tx_if;
    logic [19:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  out_data;
    logic        out_valid;
    logic        out_ready;
    logic        out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/word_split_tx.sv
// Purpose : buffers 20-bit words and transmits each as two 10-bit halves (low first), framed by out_last.
// Latency : word pushed into an empty block at edge N shows its low half on out_valid after edge N+1.
// Backpr. : in_ready = occupancy < DEPTH (no bypass when full); outputs are registered and hold while out_ready = 0.
// Ports   : clk, rst_n (async, active-low); bus (word_split_tx_if.slave); count = buffer occupancy in words.
// Option  : define WORD_SPLIT_TX_CHECKSUM_EN to append a 20-bit XOR checksum (two extra halves) to every frame.
module word_split_tx #(
    parameter int DEPTH     = 4,
    parameter int FRAME_LEN = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    word_split_tx_if.slave          bus,
    output logic [$clog2(DEPTH):0]  count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
    localparam logic [7:0]    LAST_IDX = 8'(FRAME_LEN - 1);

`ifdef WORD_SPLIT_TX_CHECKSUM_EN
    typedef enum logic [2:0] {S_IDLE, S_LOW, S_HIGH, S_CS_LO, S_CS_HI} state_t;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH} state_t;
`endif

    state_t         state_q, state_d;
    logic [19:0]    mem_q [DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [7:0]     fcnt_q, fcnt_d;
    logic [9:0]     out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;
    logic           out_last_q, out_last_d;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
    logic [19:0]    csum_q, csum_d;
`endif

    logic           in_ready_w;
    logic           push;
    logic           pop;
    logic [19:0]    head;
    logic [9:0]     head_nxt_lo;
    logic           frame_end;

    assign in_ready_w  = (count_q < DEPTH_C);
    assign push        = bus.in_valid && in_ready_w;
    assign head        = mem_q[rd_ptr_q];
    // Low half of the word behind the head: needed when HIGH hands off straight to the next word.
    assign head_nxt_lo = mem_q[rd_ptr_q + AW'(1)][9:0];
    assign frame_end   = (fcnt_q == LAST_IDX);

    assign bus.in_ready  = in_ready_w;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_last  = out_last_q;
    assign count         = count_q;

    // Storage carries data only, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    always_comb begin
        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        out_last_d  = out_last_q;
        fcnt_d      = fcnt_q;
        pop         = 1'b0;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
        csum_d      = csum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    state_d     = S_LOW;
                    out_valid_d = 1'b1;
                    out_data_d  = head[9:0];
                    out_last_d  = 1'b0;
                end
            end
            S_LOW: begin
                if (bus.out_ready) begin
                    state_d    = S_HIGH;
                    out_data_d = head[19:10];
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
                    out_last_d = 1'b0;
`else
                    out_last_d = frame_end;
`endif
                end
            end
            S_HIGH: begin
                if (bus.out_ready) begin
                    pop        = 1'b1;
                    fcnt_d     = frame_end ? 8'd0 : fcnt_q + 8'd1;
                    out_last_d = 1'b0;
                    // Occupancy after this pop decides; a same-cycle push is picked up via IDLE.
                    if (count_q > CW'(1)) begin
                        state_d    = S_LOW;
                        out_data_d = head_nxt_lo;
                    end else begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                    end
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
                    // Final word is folded in before its checksum is sent.
                    csum_d = csum_q ^ head;
                    if (frame_end) begin
                        state_d     = S_CS_LO;
                        out_valid_d = 1'b1;
                        out_data_d  = csum_d[9:0];
                    end
`endif
                end
            end
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
            S_CS_LO: begin
                if (bus.out_ready) begin
                    state_d    = S_CS_HI;
                    out_data_d = csum_q[19:10];
                    out_last_d = 1'b1;
                end
            end
            S_CS_HI: begin
                if (bus.out_ready) begin
                    csum_d     = '0;
                    fcnt_d     = 8'd0;
                    out_last_d = 1'b0;
                    if (count_q != '0) begin
                        state_d    = S_LOW;
                        out_data_d = head[9:0];
                    end else begin
                        state_d     = S_IDLE;
                        out_valid_d = 1'b0;
                        out_data_d  = '0;
                    end
                end
            end
`endif
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_last_d  = 1'b0;
            end
        endcase
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            fcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q     <= count_d;
            fcnt_q      <= fcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_word_split_tx.sv
// Purpose : self-checking bench for word_split_tx against a queue-based half-word stream model.
// Latency : n/a.
// Backpr. : bench drives random and directed out_ready patterns.
`timescale 1ns/1ps
module tb_word_split_tx;
    localparam int DEPTH     = 4;
    localparam int FRAME_LEN = 8;
    localparam int CW        = $clog2(DEPTH) + 1;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
    localparam int FRAME_HALVES = 2 * FRAME_LEN + 2;
`else
    localparam int FRAME_HALVES = 2 * FRAME_LEN;
`endif

    typedef struct packed {
        logic [9:0] dat;
        logic       last;
        logic       pops;
    } half_t;

    logic          clk;
    logic          rst_n;
    logic [CW-1:0] count;

    word_split_tx_if bus_if ();

    word_split_tx #(.DEPTH(DEPTH), .FRAME_LEN(FRAME_LEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .count (count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    int          total = 0;
    int          bad   = 0;
    half_t       exp_q [$];
    logic [10:0] log_q [$];
    int          occ;
    int          fidx;
    logic [19:0] csum;
    int          pushes   = 0;
    int          hs_total = 0;
    bit          prev_stall;
    logic [9:0]  prev_dat;
    logic        prev_last;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, want);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        occ        = 0;
        fidx       = 0;
        csum       = '0;
        prev_stall = 1'b0;
    endfunction

    // Every accepted word expands into its halves; frame end and checksum follow from the word count.
    function automatic void model_push(input logic [19:0] w);
        half_t h;
        fidx++;
        csum   = csum ^ w;
        h.dat  = w[9:0];
        h.last = 1'b0;
        h.pops = 1'b0;
        exp_q.push_back(h);
        h.dat  = w[19:10];
        h.pops = 1'b1;
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
        h.last = 1'b0;
`else
        h.last = (fidx == FRAME_LEN);
`endif
        exp_q.push_back(h);
        if (fidx == FRAME_LEN) begin
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
            h.pops = 1'b0;
            h.dat  = csum[9:0];
            h.last = 1'b0;
            exp_q.push_back(h);
            h.dat  = csum[19:10];
            h.last = 1'b1;
            exp_q.push_back(h);
`endif
            fidx = 0;
            csum = '0;
        end
    endfunction

    // Called just after a falling edge: samples, scores this cycle's handshakes, waits one cycle.
    task automatic tick();
        half_t e;
        bit    push;
        bit    hs;
        #1;
        check("count", 32'(count), 32'(occ));
        check("in_ready", 32'(bus_if.in_ready), 32'(occ < DEPTH));
        if (prev_stall) begin
            check("hold_valid", 32'(bus_if.out_valid), 32'(1));
            check("hold_data", 32'(bus_if.out_data), 32'(prev_dat));
            check("hold_last", 32'(bus_if.out_last), 32'(prev_last));
        end
        push = bus_if.in_valid && bus_if.in_ready;
        hs   = bus_if.out_valid && bus_if.out_ready;
        if (hs) begin
            hs_total++;
            log_q.push_back({bus_if.out_last, bus_if.out_data});
            if (exp_q.size() == 0) begin
                check("spurious_half", 32'(bus_if.out_data), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("out_data", 32'(bus_if.out_data), 32'(e.dat));
                check("out_last", 32'(bus_if.out_last), 32'(e.last));
                if (e.pops) occ--;
            end
        end
        prev_stall = bus_if.out_valid && !bus_if.out_ready;
        prev_dat   = bus_if.out_data;
        prev_last  = bus_if.out_last;
        if (push) begin
            pushes++;
            occ++;
            model_push(bus_if.in_data);
        end
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        bus_if.in_valid = 1'b0;
        model_reset();
        #1;
        check("rst_out_valid", 32'(bus_if.out_valid), 32'(0));
        check("rst_out_data", 32'(bus_if.out_data), 32'(0));
        check("rst_out_last", 32'(bus_if.out_last), 32'(0));
        check("rst_count", 32'(count), 32'(0));
        check("rst_in_ready", 32'(bus_if.in_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic push_word(input logic [19:0] w);
        int p;
        int budget;
        p      = pushes;
        budget = 0;
        bus_if.in_data  = w;
        bus_if.in_valid = 1'b1;
        while (pushes == p && budget < 50) begin
            tick();
            budget++;
        end
        check("push_accepted", 32'(pushes - p), 32'(1));
        bus_if.in_valid = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 400) begin
            tick();
            budget++;
        end
        check("drain_left", 32'(exp_q.size()), 32'(0));
        repeat (2) tick();
    endtask

    task automatic check_frame_log(input string tag);
        int nlast;
        logic [10:0] ent;
        nlast = 0;
        foreach (log_q[i]) if (log_q[i][10]) nlast++;
        check({tag, "_halves"}, 32'(log_q.size()), 32'(FRAME_HALVES));
        check({tag, "_nlast"}, 32'(nlast), 32'(1));
        if (log_q.size() >= FRAME_HALVES) begin
            ent = log_q[FRAME_HALVES-1];
            check({tag, "_final_last"}, 32'(ent[10]), 32'(1));
        end
    endtask

    initial begin
        logic [19:0] w1;
        logic [19:0] w3;
        logic [10:0] ent;
        int          p0;
        int          h0;
        int          budget;

        rst_n            = 1'b0;
        bus_if.in_data   = '0;
        bus_if.in_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        model_reset();
        @(negedge clk);
        apply_reset();

        // Single word 0xABCDE, sink always ready.
        bus_if.out_ready = 1'b1;
        bus_if.in_data   = 20'hABCDE;
        bus_if.in_valid  = 1'b1;
        tick();
        bus_if.in_valid = 1'b0;
        check("t1_not_yet", 32'(bus_if.out_valid), 32'(0));
        tick();
        check("t1_valid", 32'(bus_if.out_valid), 32'(1));
        check("t1_low", 32'(bus_if.out_data), 32'h0DE);
        tick();
        check("t1_high", 32'(bus_if.out_data), 32'h2AF);
        check("t1_last", 32'(bus_if.out_last), 32'(0));
        tick();
        check("t1_count", 32'(count), 32'(0));
        check("t1_idle", 32'(bus_if.out_valid), 32'(0));

        // Fill with the sink stalled; the fifth offer must be refused.
        bus_if.out_ready = 1'b0;
        p0 = pushes;
        w1 = 20'($urandom);
        for (int i = 0; i < 5; i++) begin
            bus_if.in_data  = (i == 0) ? w1 : 20'($urandom);
            bus_if.in_valid = 1'b1;
            tick();
        end
        bus_if.in_valid = 1'b0;
        check("t2_accepted", 32'(pushes - p0), 32'(4));
        check("t2_count_full", 32'(count), 32'(DEPTH));
        check("t2_in_ready", 32'(bus_if.in_ready), 32'(0));
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_hold_w1_low", 32'(bus_if.out_data), 32'(w1[9:0]));
        end
        drain();

        // One full frame of words 1..8.
        apply_reset();
        log_q.delete();
        bus_if.out_ready = 1'b1;
        for (int i = 1; i <= FRAME_LEN; i++) push_word(20'(i));
        drain();
        check_frame_log("t3");
        if (log_q.size() >= FRAME_HALVES) begin
            ent = log_q[FRAME_HALVES-1];
            check("t3_final_value", 32'(ent[9:0]), 32'h000);
`ifdef WORD_SPLIT_TX_CHECKSUM_EN
            ent = log_q[FRAME_HALVES-2];
            check("t3_csum_low", 32'(ent), 32'h008);
`endif
        end

        // 64 words at full input rate against a sink toggling every cycle.
        p0 = pushes;
        budget = 0;
        bus_if.in_data  = 20'($urandom);
        bus_if.in_valid = 1'b1;
        while ((pushes - p0) < 64 && budget < 1000) begin
            bus_if.out_ready = ~bus_if.out_ready;
            h0 = pushes;
            tick();
            if (pushes != h0) bus_if.in_data = 20'($urandom);
            budget++;
        end
        check("t4_pushed", 32'(pushes - p0), 32'(64));
        drain();

        // Random traffic on both sides.
        for (int i = 0; i < 400; i++) begin
            bus_if.in_valid  = 1'($urandom_range(0, 1));
            bus_if.in_data   = 20'($urandom);
            bus_if.out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drain();

        // Reset while word 3 is in its high half with two words buffered.
        apply_reset();
        bus_if.out_ready = 1'b0;
        push_word(20'($urandom));
        push_word(20'($urandom));
        w3 = 20'($urandom);
        push_word(w3);
        push_word(20'($urandom));
        bus_if.out_ready = 1'b1;
        h0 = hs_total;
        budget = 0;
        while ((hs_total - h0) < 5 && budget < 40) begin
            tick();
            budget++;
        end
        bus_if.out_ready = 1'b0;
        check("t6_in_high", 32'(bus_if.out_data), 32'(w3[19:10]));
        check("t6_buffered", 32'(count), 32'(2));
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t6_rst_valid", 32'(bus_if.out_valid), 32'(0));
        check("t6_rst_count", 32'(count), 32'(0));
        check("t6_rst_in_ready", 32'(bus_if.in_ready), 32'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        bus_if.out_ready = 1'b1;
        repeat (4) tick();
        log_q.delete();
        push_word(20'h12345);
        budget = 0;
        while (log_q.size() < 2 && budget < 20) begin
            tick();
            budget++;
        end
        check("t6_halves_seen", 32'(log_q.size()), 32'(2));
        if (log_q.size() >= 2) begin
            check("t6_low", 32'(log_q[0]), 32'h345);
            check("t6_high", 32'(log_q[1]), 32'h048);
        end
        for (int i = 0; i < FRAME_LEN - 1; i++) push_word(20'($urandom));
        drain();
        check_frame_log("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
